// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential instruction fetch front end.
// Issues word-aligned fetch requests under a credit limit. Buffers in-order
// memory responses together with their PCs in a small FIFO. Presents the FIFO
// head to decode through a valid/ready handshake. A redirect flushes the FIFO
// and arranges for responses that are still in flight to be dropped.
// Optional build macro IFQ_PERF_COUNTERS_EN adds three saturating 32-bit
// counters: perf_fetched, perf_dropped and perf_stall.
module instr_fetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef IFQ_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped,
    output logic [31:0] perf_stall
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } fq_entry_t;

    fq_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] occ, outstanding, drop_cnt;
    logic [31:0]   fetch_pc, resp_pc;
    logic [CW:0]   credit_sum;
    logic          resp, enq, deq, issue;
    logic [31:0]   redir_base;
    logic          unused_redir_lsbs;

    // The low address bits of a redirect target are deliberately discarded.
    assign redir_base        = {redirect_pc[31:2], 2'b00};
    assign unused_redir_lsbs = ^redirect_pc[1:0];

    // A response only counts while a request is in flight. This discards
    // stragglers from before a reset.
    assign resp  = imem_rvalid && (outstanding != '0);
    assign enq   = resp && (drop_cnt == '0) && !redirect;

    // Every in-flight request holds a FIFO slot, so a response never overflows.
    assign credit_sum = {1'b0, occ} + {1'b0, outstanding};
    assign issue      = !rst && !redirect
                        && (credit_sum < (CW+1)'(DEPTH))
                        && (outstanding < CW'(MAX_OUTSTANDING));

    assign imem_req    = issue;
    assign imem_addr   = fetch_pc;
    assign instr_valid = (occ != '0) && !redirect;
    assign deq         = instr_valid && instr_ready;
    assign instr       = mem[rd_ptr].word;
    assign instr_pc    = mem[rd_ptr].pc;

    // Fetch address and the PC tagged onto the next accepted response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redir_base;
            resp_pc  <= redir_base;
        end else begin
            if (issue) fetch_pc <= fetch_pc + 32'd4;
            if (enq)   resp_pc  <= resp_pc + 32'd4;
        end
    end

    // In-flight request count. On redirect, the count of wrong-path responses still to discard is also set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(resp);
            if (redirect)
                drop_cnt <= outstanding - CW'(resp);
            else if (resp && (drop_cnt != '0))
                drop_cnt <= drop_cnt - 1'b1;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + CW'(enq) - CW'(deq);
        end
    end

    // FIFO storage. It is cleared on reset, so the head outputs read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (enq) begin
            mem[wr_ptr] <= '{word: imem_rdata, pc: resp_pc};
        end
    end

`ifdef IFQ_PERF_COUNTERS_EN
    // Saturating event counters for accepted words, discarded responses and decode starvation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
            perf_stall   <= '0;
        end else begin
            if (enq && (perf_fetched != '1))
                perf_fetched <= perf_fetched + 32'd1;
            if (resp && !enq && (perf_dropped != '1))
                perf_dropped <= perf_dropped + 32'd1;
            if (instr_ready && !instr_valid && (perf_stall != '1))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: scoreboard bench for instr_fetch_queue.
// A behavioural memory answers requests in order after a programmable latency.
// Responses on the correct path push the expected {pc, word} into a queue, and
// decode-side deliveries are popped and compared against it.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_rvalid, redirect, instr_valid, instr_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;

    logic        w_req, w_rvalid, w_valid;
    logic [31:0] w_addr, w_instr, w_pc;

`ifdef IFQ_PERF_COUNTERS_EN
    logic [31:0] pf_f, pf_d, pf_s, wpf_f, wpf_d, wpf_s;
`endif

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
`ifdef IFQ_PERF_COUNTERS_EN
        , .perf_fetched(pf_f), .perf_dropped(pf_d), .perf_stall(pf_s)
`endif
    );

    // Second instance that only checks address wrap from a high reset PC.
    instr_fetch_queue #(.DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(w_rvalid), .imem_rdata(32'h0),
        .redirect(1'b0), .redirect_pc(32'h0),
        .instr_valid(w_valid), .instr_ready(1'b1),
        .instr(w_instr), .instr_pc(w_pc)
`ifdef IFQ_PERF_COUNTERS_EN
        , .perf_fetched(wpf_f), .perf_dropped(wpf_d), .perf_stall(wpf_s)
`endif
    );

    always @(posedge clk or posedge rst)
        if (rst) w_rvalid <= 1'b0;
        else     w_rvalid <= w_req;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          wrong;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    pend_t       pend[$];
    exp_t        expq[$];
    int          n_chk = 0, n_err = 0;
    int          cyc = 0, lat = 1, last_due = -1;
    int          n_req = 0, n_deq = 0, wcyc = 0;
    int          first_req_cyc = -1, first_vld_cyc = -1;
    bit          prev_redir = 1'b0;
    logic [31:0] exp_fetch = 32'h0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // One clock cycle, entered and left on a falling edge.
    task automatic cycle(input bit ready, input bit redir, input logic [31:0] rpc);
        bit    rv;
        pend_t p;
        int    d;
        rv = 1'b0;
        p  = '{32'h0, 0, 1'b0};
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            p  = pend.pop_front();
            rv = 1'b1;
        end
        imem_rvalid = rv;
        imem_rdata  = rv ? ~p.addr : 32'h0;
        instr_ready = ready;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
        chk("inv_credit", 32'((32'(u_dut.occ) + 32'(u_dut.outstanding)) > 32'd4), 32'd0);
        chk("inv_drop", 32'(u_dut.drop_cnt > u_dut.outstanding), 32'd0);
        if (prev_redir) chk("empty_after_redir", 32'(instr_valid), 32'd0);
        if (redir) begin
            chk("redir_req", 32'(imem_req), 32'd0);
            chk("redir_vld", 32'(instr_valid), 32'd0);
            foreach (pend[i]) pend[i].wrong = 1'b1;
            expq.delete();
            exp_fetch = {rpc[31:2], 2'b00};
        end else begin
            if (instr_valid) begin
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                if (expq.size() == 0) begin
                    chk("spurious_vld", 32'(instr_valid), 32'd0);
                end else begin
                    chk("instr_pc", instr_pc, expq[0].pc);
                    chk("instr", instr, expq[0].word);
                    if (ready) begin
                        void'(expq.pop_front());
                        n_deq++;
                    end
                end
            end
            if (rv && !p.wrong) expq.push_back('{p.addr, ~p.addr});
            if (imem_req) begin
                if (first_req_cyc < 0) first_req_cyc = cyc;
                chk("imem_addr", imem_addr, exp_fetch);
                chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
                d = cyc + lat;
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                pend.push_back('{exp_fetch, d, 1'b0});
                exp_fetch = exp_fetch + 32'd4;
                n_req++;
            end
        end
        if (wcyc < 3) begin
            chk("wrap_req", 32'(w_req), 32'd1);
            chk("wrap_addr", w_addr, 32'hFFFF_FFF8 + 32'(4 * wcyc));
            wcyc++;
        end
        prev_redir = redir;
        @(negedge clk);
        cyc++;
    endtask

    // Asynchronous reset pulse lasting one cycle. Memory responses still in flight keep arriving afterwards.
    task automatic reset_cycle();
        pend_t p;
        rst         = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            p           = pend.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = ~p.addr;
        end
        redirect = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_vld", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_outst", 32'(u_dut.outstanding), 32'd0);
        foreach (pend[i]) pend[i].wrong = 1'b1;
        expq.delete();
        exp_fetch  = 32'h0;
        prev_redir = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc++;
    endtask

    initial begin
        int snap;
        bit found;
        rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
        #1;
        chk("reset_req", 32'(imem_req), 32'd0);
        chk("reset_vld", 32'(instr_valid), 32'd0);
        chk("reset_instr", instr, 32'd0);
        chk("reset_pc", instr_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Latency 1 with decode always ready: one instruction per cycle after a two-cycle fill.
        lat = 1;
        snap = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 10) snap = n_deq;
            cycle(1'b1, 1'b0, 32'h0);
        end
        chk("first_vld_lat", 32'(first_vld_cyc - first_req_cyc), 32'd2);
        chk("throughput", 32'(n_deq - snap), 32'd20);

        // Decode stalled: only DEPTH requests go out and the head stays on 0x0.
        cycle(1'b0, 1'b1, 32'h0);
        snap = n_req;
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0);
        chk("stall_reqs", 32'(n_req - snap), 32'd4);
        chk("stall_head_vld", 32'(instr_valid), 32'd1);
        chk("stall_head_pc", instr_pc, 32'h0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0);

        // Latency 3 with two requests in flight; redirect to 0x103, low bits ignored.
        lat = 3;
        cycle(1'b1, 1'b1, 32'h20);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("inflight", 32'(u_dut.outstanding), 32'd2);
        cycle(1'b1, 1'b1, 32'h103);
        chk("drop_after_redir", 32'(u_dut.drop_cnt), 32'd2);
        snap = n_deq;
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 32'h0);
        chk("drop_drained", 32'(u_dut.drop_cnt), 32'd0);
        chk("delivered_after_redir", 32'(n_deq > snap), 32'd1);

        // Back-to-back redirects: the last one wins.
        cycle(1'b1, 1'b1, 32'h200);
        cycle(1'b1, 1'b1, 32'h300);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 32'h0);

        // Redirect in the same cycle as a response, with a valid head.
        lat = 1;
        cycle(1'b0, 1'b1, 32'h340);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("head_before_redir", 32'(instr_valid), 32'd1);
        chk("resp_in_redir", 32'(pend.size() > 0 && pend[0].due <= cyc), 32'd1);
        cycle(1'b0, 1'b1, 32'h400);
        chk("outst_after_redir", 32'(u_dut.outstanding), 32'd0);
        chk("drop_zero", 32'(u_dut.drop_cnt), 32'd0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0);

        // Address wrap through a redirect near the top of memory.
        cycle(1'b1, 1'b1, 32'hFFFF_FFF4);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0);

        // Reset while two requests are in flight; their late responses must be ignored.
        lat = 3;
        cycle(1'b1, 1'b1, 32'h500);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pend.size() == 2 && pend[0].due == cyc) found = 1'b1;
            else cycle(1'b1, 1'b0, 32'h0);
        end
        chk("rst_setup", 32'(found), 32'd1);
        reset_cycle();
        cycle(1'b1, 1'b0, 32'h0);
        chk("post_rst_vld", 32'(instr_valid), 32'd0);
        snap = n_deq;
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 32'h0);
        chk("post_rst_deliver", 32'(n_deq > snap), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch front end that sits directly upstream of the instruction word split and decode path.
- Generates sequential word addresses to instruction memory and tolerates in-order responses of any latency of 1 cycle or more.
- Buffers fetched words with their PCs in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts a redirect (taken branch / jump) that flushes everything fetched on the wrong path.

Parameters:
- DEPTH, 4: instruction FIFO entries; power of two, at least 2.
- MAX_OUTSTANDING, 2: maximum memory requests in flight; 1 to DEPTH.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req  out  1  request pulse; memory always accepts it in the same cycle.
- imem_addr  out  32  byte address of the request; always word aligned.
- imem_rvalid  in  1  response valid; responses return in request order.
- imem_rdata  in  32  instruction word.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and treated as 0.
- instr_valid  out  1  FIFO head is valid.
- instr_ready  in  1  decode accepts the head.
- instr  out  32  head instruction word.
- instr_pc  out  32  PC of the head instruction.

Behaviour:
- Reset (async, active-high):
  - fetch_pc = RESET_PC; resp_pc = RESET_PC.
  - FIFO empty; outstanding = 0; drop_cnt = 0.
  - imem_req = 0; instr_valid = 0; instr = 0; instr_pc = 0.
  - Any imem_rvalid arriving while outstanding = 0 is ignored. This covers responses to requests issued before a mid-operation reset.
- Issue:
  - imem_req = !rst && !redirect && (occupancy + outstanding < DEPTH) && (outstanding < MAX_OUTSTANDING).
  - imem_addr = fetch_pc.
  - On issue, fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0) and outstanding += 1.
  - The credit rule guarantees a free FIFO slot for every response; the FIFO never overflows.
- Response (imem_rvalid with outstanding > 0):
  - outstanding -= 1.
  - If drop_cnt > 0: the word is discarded and drop_cnt -= 1.
  - Otherwise {imem_rdata, resp_pc} is enqueued and resp_pc += 4.
  - Issue and response in the same cycle leave outstanding unchanged.
- Output:
  - instr_valid = (occupancy > 0) && !redirect.
  - instr and instr_pc come from the FIFO head and are held stable while instr_valid && !instr_ready.
  - Dequeue occurs on instr_valid && instr_ready.
  - Enqueue and dequeue in the same cycle leave occupancy unchanged; this is legal when full.
  - An enqueue into an empty FIFO is visible on instr_valid the next cycle (one cycle of added latency).
- Redirect (highest priority):
  - In the cycle redirect = 1, no request is issued and instr_valid is forced to 0.
  - Next state: FIFO empty; fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - drop_cnt = outstanding - (imem_rvalid ? 1 : 0); a response arriving in the redirect cycle is discarded.
  - Consecutive redirects: the last one wins; drop_cnt is recomputed each cycle from the current outstanding count.
  - Fetching resumes on the first cycle with redirect = 0.
- Invariants (bench assertions):
  - occupancy + outstanding <= DEPTH.
  - drop_cnt <= outstanding.
  - imem_addr[1:0] == 0.

Optional Feature:
- Macro: IFQ_PERF_COUNTERS_EN.
- When defined, three 32-bit outputs are added, each reset to 0 and saturating at 32'hFFFF_FFFF:
  - perf_fetched: enqueued words.
  - perf_dropped: discarded responses.
  - perf_stall: cycles with instr_ready = 1 and instr_valid = 0.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, memory latency 1, instr_ready held 1 -> imem_addr 0x0, 0x4, 0x8 … on consecutive cycles; first instr_valid at cycle 3 with instr_pc 0x0; steady-state throughput 1 instr/cycle.
- instr_ready = 0 for 10 cycles, latency 1, DEPTH 4 -> exactly 4 requests issued, FIFO full, imem_req held 0, head instr_pc 0x0 stable; release -> PCs 0x0–0xC delivered in order, then fetch resumes at 0x10.
- Latency 3, two requests in flight (0x20, 0x24), redirect to 0x100 -> both responses dropped (drop_cnt 2 -> 0); next delivered instr_pc 0x100; no 0x20/0x24 word reaches decode.
- Redirect asserted in the same cycle as a response and with a valid head -> instr_valid 0 that cycle, response discarded, FIFO empty next cycle.
- redirect_pc 32'h0000_0103 -> fetch restarts at 0x100; RESET_PC 0xFFFF_FFF8 -> fetch sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- rst pulsed mid-run with 2 outstanding requests and late responses arriving after reset -> late responses ignored; fetch restarts at RESET_PC; instr_valid 0 until the new first word arrives.
